// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin burst read scheduler sharing one consumer among N async FIFO read ports
// Optional macro ARB_STRICT_PRIO_EN: grant the lowest-index non-empty FIFO instead of round-robin.
module fifo_rd_arbiter #(
    parameter int N_FIFO    = 4,
    parameter int BURST_LEN = 4,
    parameter int IDX_W     = $clog2(N_FIFO)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_FIFO-1:0] fifo_empty,
    input  logic              out_ready,
    output logic [N_FIFO-1:0] fifo_r_en,
    output logic              grant_vld,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] burst_cnt;
    logic [IDX_W-1:0] last_idx, sel_idx;
    logic             sel_vld, rd, done;
`ifndef ARB_STRICT_PRIO_EN
    int               j;
`endif

    // candidate for the next grant; reverse scan so the first hit in search order wins
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
`ifdef ARB_STRICT_PRIO_EN
        for (int i = N_FIFO - 1; i >= 0; i--)
            if (!fifo_empty[i]) begin
                sel_idx = IDX_W'(i);
                sel_vld = 1'b1;
            end
`else
        j = 0;
        for (int k = N_FIFO; k >= 1; k--) begin
            j = int'(last_idx) + k;
            j = (j >= N_FIFO) ? j - N_FIFO : j;
            if (!fifo_empty[j]) begin
                sel_idx = IDX_W'(j);
                sel_vld = 1'b1;
            end
        end
`endif
    end

    // read strobe to the granted FIFO (never past empty) and burst exit / next-state decode
    always_comb begin
        rd = (state == BURST) && !fifo_empty[grant_idx] && out_ready;
        fifo_r_en = '0;
        fifo_r_en[grant_idx] = rd;
        done = fifo_empty[grant_idx] || (rd && burst_cnt == CNT_W'(BURST_LEN - 1));
        state_n = state;
        if (state == IDLE && en && sel_vld)
            state_n = BURST;
        else if (state == BURST && done)
            state_n = IDLE;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // grant bookkeeping: latch the winner in IDLE, count reads and remember the owner on exit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_vld <= 1'b0;
            grant_idx <= '0;
            burst_cnt <= '0;
            last_idx  <= IDX_W'(N_FIFO - 1);
        end else if (state == IDLE) begin
            if (en && sel_vld) begin
                grant_vld <= 1'b1;
                grant_idx <= sel_idx;
                burst_cnt <= '0;
            end
        end else begin
            if (rd)
                burst_cnt <= burst_cnt + CNT_W'(1);
            if (done) begin
                grant_vld <= 1'b0;
                last_idx  <= grant_idx;
            end
        end
    end

    // valid/index strobe aligned with the FIFO's one-cycle synchronous read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            out_valid <= rd;
            if (rd)
                out_idx <= grant_idx;
        end
    end

    assign busy = (state != IDLE) || out_valid;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: vector table, directed corner sequences and random traffic against a burst-level model
module tb_fifo_rd_arbiter;
    localparam int N  = 4;
    localparam int BL = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] fifo_empty = '1;
    logic [N-1:0] fifo_r_en;
    logic         grant_vld, out_valid, busy;
    logic [1:0]   grant_idx, out_idx;

    fifo_rd_arbiter #(.N_FIFO(N), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .out_ready(out_ready),
        .fifo_r_en(fifo_r_en), .grant_vld(grant_vld), .grant_idx(grant_idx),
        .out_valid(out_valid), .out_idx(out_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        bit         rdy;
        logic [3:0] emp;
        logic [3:0] ren;
        bit         gv;
        int         gi;
        bit         ov;
        int         oi;
    } vec_t;

    vec_t tv[25];
    int   occ[N];
    int   rd_cnt[N];
    int   glog[$];
    int   total = 0;
    int   bad = 0;
    bit   prev_gv;
    bit   m_act, m_ov;
    int   m_g, m_left, m_last, m_oi;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic upd_empty();
        for (int i = 0; i < N; i++) fifo_empty[i] = (occ[i] == 0);
    endtask

    function automatic int choose();
`ifdef ARB_STRICT_PRIO_EN
        for (int k = 0; k < N; k++) if (occ[k] > 0) return k;
`else
        for (int k = 1; k <= N; k++) if (occ[(m_last + k) % N] > 0) return (m_last + k) % N;
`endif
        return -1;
    endfunction

    function automatic logic [3:0] m_ren();
        return (m_act && occ[m_g] > 0 && out_ready) ? 4'(1 << m_g) : 4'd0;
    endfunction

    // one clock: compare against the model at negedge, then advance model and FIFO occupancy
    task automatic tick();
        logic [3:0] er;
        int pick;
        @(negedge clk);
        er = m_ren();
        chk("r_en", int'(fifo_r_en), int'(er));
        chk("grant_vld", int'(grant_vld), int'(m_act));
        if (m_act) chk("grant_idx", int'(grant_idx), m_g);
        chk("out_valid", int'(out_valid), int'(m_ov));
        if (m_ov) chk("out_idx", int'(out_idx), m_oi);
        chk("busy", int'(busy), int'(m_act || m_ov));
        if (grant_vld && !prev_gv) glog.push_back(int'(grant_idx));
        prev_gv = grant_vld;
        for (int i = 0; i < N; i++) if (fifo_r_en[i]) rd_cnt[i]++;
        if (!m_act) begin
            pick = en ? choose() : -1;
            if (pick >= 0) begin
                m_act = 1; m_g = pick; m_left = BL;
            end
        end else if (occ[m_g] == 0) begin
            m_act = 0; m_last = m_g;
        end else if (er != 0) begin
            m_left--;
            if (m_left == 0) begin
                m_act = 0; m_last = m_g;
            end
        end
        m_ov = (er != 0);
        if (er != 0) begin
            m_oi = m_g;
            occ[m_g]--;
        end
        @(posedge clk);
        #1;
        upd_empty();
    endtask

    task automatic rst_checks();
        chk("rst_r_en", int'(fifo_r_en), 0);
        chk("rst_grant_vld", int'(grant_vld), 0);
        chk("rst_grant_idx", int'(grant_idx), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_busy", int'(busy), 0);
    endtask

    task automatic release_rst();
        m_act = 0; m_ov = 0; m_oi = 0; m_last = N - 1; prev_gv = 0;
        glog.delete();
        for (int i = 0; i < N; i++) rd_cnt[i] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        upd_empty();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst_checks();
        release_rst();
    endtask

    task automatic set_occ(int a, int b, int c, int d);
        occ[0] = a; occ[1] = b; occ[2] = c; occ[3] = d;
        upd_empty();
    endtask

    initial begin
        int b, ph, sum;
        // back-to-back bursts with every FIFO full: 1 idle + BL reads per grant
        for (int c = 0; c < 25; c++) begin
            b = c / 5;
            ph = c % 5;
            tv[c].en  = 1;
            tv[c].rdy = 1;
            tv[c].emp = 4'd0;
`ifdef ARB_STRICT_PRIO_EN
            tv[c].gi = 0;
            tv[c].oi = 0;
`else
            tv[c].gi = b % 4;
            tv[c].oi = (ph == 0) ? (b + 3) % 4 : b % 4;
`endif
            tv[c].gv  = (ph != 0);
            tv[c].ren = (ph != 0) ? 4'(1 << tv[c].gi) : 4'd0;
            tv[c].ov  = (c > 0) && (ph != 1);
        end

        set_occ(100, 100, 100, 100);
        en = 1; out_ready = 1;
        do_reset();
        for (int c = 0; c < 25; c++) begin
            en = tv[c].en; out_ready = tv[c].rdy; fifo_empty = tv[c].emp;
            @(negedge clk);
            chk("tv_r_en", int'(fifo_r_en), int'(tv[c].ren));
            chk("tv_grant_vld", int'(grant_vld), int'(tv[c].gv));
            if (tv[c].gv) chk("tv_grant_idx", int'(grant_idx), tv[c].gi);
            chk("tv_out_valid", int'(out_valid), int'(tv[c].ov));
            if (tv[c].ov) chk("tv_out_idx", int'(out_idx), tv[c].oi);
            @(posedge clk);
            #1;
        end

        // FIFO 2 holds two words: two reads, exit on empty, then nothing
        set_occ(0, 0, 2, 0);
        do_reset();
        repeat (8) tick();
        chk("f2_reads", rd_cnt[2], 2);
        sum = rd_cnt[0] + rd_cnt[1] + rd_cnt[3];
        chk("f2_other_reads", sum, 0);
        chk("f2_grants", glog.size(), 1);
        chk("f2_idle_gv", int'(grant_vld), 0);

        // out_ready stall in the middle of a FIFO 1 burst
        set_occ(0, 10, 0, 0);
        do_reset();
        repeat (3) tick();
        out_ready = 0;
        repeat (3) begin
            #1;
            chk("stall_r_en", int'(fifo_r_en), 0);
            chk("stall_gv", int'(grant_vld), 1);
            tick();
        end
        out_ready = 1;
        repeat (3) tick();
        chk("stall_reads", rd_cnt[1], 4);
        chk("stall_grants", glog.size(), 1);

        // en low blocks grants; dropping en mid-burst lets the burst finish
        set_occ(100, 100, 100, 100);
        en = 0;
        do_reset();
        repeat (5) tick();
        chk("en0_grants", glog.size(), 0);
        en = 1;
        tick();
        en = 0;
        repeat (10) tick();
        sum = rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
        chk("en_drop_reads", sum, 4);
        chk("en_drop_grants", glog.size(), 1);

        // async reset during the 2nd read of the FIFO 2 burst
        en = 1;
        do_reset();
        repeat (12) tick();
        #1;
        chk("pre_rst_r_en", int'(fifo_r_en), 4);
        rst = 1'b1;
        #1;
        rst_checks();
        release_rst();
        repeat (3) tick();
        chk("post_rst_grants", glog.size(), 1);
        if (glog.size() > 0) chk("post_rst_first", glog[0], 0);

        // only FIFOs 0 and 3 busy
        set_occ(100, 0, 0, 100);
        do_reset();
        repeat (20) tick();
        chk("p03_grants", glog.size(), 4);
        for (int i = 0; i < glog.size(); i++)
`ifdef ARB_STRICT_PRIO_EN
            chk("p03_order", glog[i], 0);
`else
            chk("p03_order", glog[i], (i % 2) ? 3 : 0);
`endif

        // random traffic against the model
        set_occ(3, 0, 5, 1);
        do_reset();
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) occ[i] += $urandom_range(0, 3);
            upd_empty();
            tick();
            if (c == 300) begin
                rst = 1'b1;
                #1;
                rst_checks();
                release_rst();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
